// File: rtl/plot_arbiter.sv
// Round-robin arbiter that scans one of two requested rectangles onto the framebuffer write port.
// Optional debug LEDs (ledr) are built in when PLOT_ARB_DEBUG_EN is defined.
module plot_arbiter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int S_W      = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic             req1,
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  input  logic [S_W-1:0]   w0,
  input  logic [S_W-1:0]   w1,
  input  logic [S_W-1:0]   h0,
  input  logic [S_W-1:0]   h1,
  input  logic [COL_W-1:0] col0,
  input  logic [COL_W-1:0] col1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [X_W-1:0]   plot_x,
  output logic [Y_W-1:0]   plot_y,
  output logic [COL_W-1:0] plot_colour,
  output logic             writeEn,
  output logic             busy
`ifdef PLOT_ARB_DEBUG_EN
  ,
  output logic [9:0]       ledr
`endif
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t           state, state_n;
  logic [X_W-1:0]   bx, bx_n;
  logic [Y_W-1:0]   by, by_n;
  logic [S_W-1:0]   bw, bw_n, bh, bh_n, cx, cx_n, cy, cy_n;
  logic [COL_W-1:0] bc, bc_n;
  logic             served, served_n, fav, fav_n, grant;
  logic             ack0_n, ack1_n, done0_n, done1_n, we_n;
  logic [X_W-1:0]   px_n;
  logic [Y_W-1:0]   py_n;
  logic [COL_W-1:0] pc_n;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  always_comb begin
    state_n  = state;
    bx_n     = bx;
    by_n     = by;
    bw_n     = bw;
    bh_n     = bh;
    bc_n     = bc;
    cx_n     = cx;
    cy_n     = cy;
    served_n = served;
    fav_n    = fav;
    grant    = 1'b0;
    ack0_n   = 1'b0;
    ack1_n   = 1'b0;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
    we_n     = 1'b0;
    px_n     = plot_x;
    py_n     = plot_y;
    pc_n     = plot_colour;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant    = (req0 & req1) ? fav : req1;
          served_n = grant;
          bx_n     = grant ? x1 : x0;
          by_n     = grant ? y1 : y0;
          bw_n     = grant ? w1 : w0;
          bh_n     = grant ? h1 : h0;
          bc_n     = grant ? col1 : col0;
          cx_n     = '0;
          cy_n     = '0;
          ack0_n   = ~grant;
          ack1_n   = grant;
          state_n  = DRAW;
        end
      end
      DRAW: begin
        if (cx == bw && cy == bh) begin
          state_n = DONE;
          done0_n = ~served;
          done1_n = served;
        end else if (cx == bw) begin
          cx_n = '0;
          cy_n = cy + 1'b1;
        end else begin
          cx_n = cx + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        // fav holds the index favoured at the next contended grant
        fav_n   = ~served;
      end
      default: state_n = IDLE;
    endcase
    // Clip test uses the carry bit so off-screen pixels never alias back on screen
    sum_x = (X_W+1)'(bx_n) + (X_W+1)'(cx_n);
    sum_y = (Y_W+1)'(by_n) + (Y_W+1)'(cy_n);
    if (state_n == DRAW) begin
      px_n = sum_x[X_W-1:0];
      py_n = sum_y[Y_W-1:0];
      pc_n = bc_n;
      we_n = (sum_x < SCR_W) && (sum_y < SCR_H);
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= IDLE;
      bx          <= '0;
      by          <= '0;
      bw          <= '0;
      bh          <= '0;
      bc          <= '0;
      cx          <= '0;
      cy          <= '0;
      served      <= 1'b0;
      fav         <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      writeEn     <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else begin
      state       <= state_n;
      bx          <= bx_n;
      by          <= by_n;
      bw          <= bw_n;
      bh          <= bh_n;
      bc          <= bc_n;
      cx          <= cx_n;
      cy          <= cy_n;
      served      <= served_n;
      fav         <= fav_n;
      ack0        <= ack0_n;
      ack1        <= ack1_n;
      done0       <= done0_n;
      done1       <= done1_n;
      writeEn     <= we_n;
      plot_x      <= px_n;
      plot_y      <= py_n;
      plot_colour <= pc_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef PLOT_ARB_DEBUG_EN
  logic ack_tog, clip_seen;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ack_tog   <= 1'b0;
      clip_seen <= 1'b0;
    end else begin
      ack_tog   <= ack_tog ^ (ack0_n | ack1_n);
      clip_seen <= clip_seen | ((state_n == DRAW) & ~we_n);
    end
  end

  assign ledr = {4'b0000, clip_seen, ack_tog, fav,
                 state == DONE, state == DRAW, state == IDLE};
`endif

endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: a rectangle-level model queues expected per-cycle beats,
// a monitor compares every busy cycle against them.
module tb_plot_arbiter;
  localparam int X_W = 8, Y_W = 7, COL_W = 3, S_W = 4;

  logic clk = 1'b0;
  logic resetn;
  logic req0, req1;
  logic [X_W-1:0] x0, x1;
  logic [Y_W-1:0] y0, y1;
  logic [S_W-1:0] w0, w1, h0, h1;
  logic [COL_W-1:0] col0, col1;
  logic ack0, ack1, done0, done1, writeEn, busy;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [COL_W-1:0] plot_colour;

  always #5 clk = ~clk;

  plot_arbiter #(
    .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .S_W(S_W), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .w0(w0), .w1(w1), .h0(h0), .h1(h1),
    .col0(col0), .col1(col1), .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .writeEn(writeEn), .busy(busy)
  );

  typedef struct {
    logic       pix;
    logic [4:0] ctl;   // {ack0, ack1, writeEn, done0, done1}
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int checks = 0;
  int errors = 0;
  int fav = 0;
  int rx[2], ry[2], rw[2], rh[2], rc[2];

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Expected output of one rectangle: raster-order pixels, then the done cycle
  function automatic void push_rect(int r, int x, int y, int w, int h, int c);
    beat_t b;
    for (int j = 0; j <= h; j++) begin
      for (int i = 0; i <= w; i++) begin
        b.pix = 1'b1;
        b.ctl = {(i == 0 && j == 0 && r == 0), (i == 0 && j == 0 && r == 1),
                 ((x + i) < 160 && (y + j) < 120), 1'b0, 1'b0};
        b.x = 8'((x + i) % 256);
        b.y = 7'((y + j) % 128);
        b.c = 3'(c);
        exp_q.push_back(b);
      end
    end
    b.pix = 1'b0;
    b.ctl = {3'b000, (r == 0), (r == 1)};
    b.x = '0;
    b.y = '0;
    b.c = '0;
    exp_q.push_back(b);
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      if (busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual ctl=%b required no busy cycle",
                   {ack0, ack1, writeEn, done0, done1});
        end else begin
          e = exp_q.pop_front();
          if ({ack0, ack1, writeEn, done0, done1} != e.ctl ||
              (e.pix && (plot_x != e.x || plot_y != e.y || plot_colour != e.c))) begin
            errors++;
            $display("FAIL beat actual ctl=%b x=%0d y=%0d col=%0d required ctl=%b x=%0d y=%0d col=%0d",
                     {ack0, ack1, writeEn, done0, done1}, plot_x, plot_y, plot_colour,
                     e.ctl, e.x, e.y, e.c);
          end
        end
      end else begin
        check("idle_strobes", int'({ack0, ack1, writeEn, done0, done1}), 0);
      end
    end
  end

  task automatic apply_reset();
    resetn = 1'b1;
    req0 = 0; req1 = 0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; w0 = '0; w1 = '0; h0 = '0; h1 = '0;
    col0 = '0; col1 = '0;
    exp_q.delete();
    fav = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({ack0, ack1, done0, done1, writeEn, busy,
                                 plot_x, plot_y, plot_colour}), 0);
    resetn = 1'b0;
  endtask

  task automatic drive_inputs();
    x0 = 8'(rx[0]); y0 = 7'(ry[0]); w0 = 4'(rw[0]); h0 = 4'(rh[0]); col0 = 3'(rc[0]);
    x1 = 8'(rx[1]); y1 = 7'(ry[1]); w1 = 4'(rw[1]); h1 = 4'(rh[1]); col1 = 3'(rc[1]);
  endtask

  // mask bit0 = req0, bit1 = req1; pulse_at > 0 flashes req1 during requester 0's rectangle
  task automatic do_txn(input int mask, input int pulse_at);
    int first, second, n1, t, budget;
    int lat[2];
    bit want[2], gotd[2];
    first  = (mask == 3) ? fav : ((mask == 2) ? 1 : 0);
    second = 1 - first;
    push_rect(first, rx[first], ry[first], rw[first], rh[first], rc[first]);
    if (mask == 3) push_rect(second, rx[second], ry[second], rw[second], rh[second], rc[second]);
    fav = (mask == 3) ? first : 1 - first;
    n1 = (rw[first] + 1) * (rh[first] + 1);
    budget = n1 + 256 + 20;
    lat[0] = -1; lat[1] = -1;
    want[0] = (mask & 1) != 0;
    want[1] = (mask & 2) != 0;
    gotd[0] = 0; gotd[1] = 0;
    @(negedge clk);
    drive_inputs();
    req0 = want[0];
    req1 = want[1];
    t = 0;
    while (t < budget && !((gotd[0] || !want[0]) && (gotd[1] || !want[1]))) begin
      @(negedge clk);
      t++;
      if (req0 && ack0) begin
        lat[0] = t; req0 = 0;
        x0 = 8'($urandom); y0 = 7'($urandom); w0 = 4'($urandom); col0 = 3'($urandom);
      end
      if (req1 && ack1) begin
        lat[1] = t; req1 = 0;
        x1 = 8'($urandom); y1 = 7'($urandom); h1 = 4'($urandom); col1 = 3'($urandom);
      end
      if (done0) gotd[0] = 1;
      if (done1) gotd[1] = 1;
      if (pulse_at > 0) begin
        if (t == pulse_at) req1 = 1;
        else if (t == pulse_at + 1) req1 = 0;
      end
    end
    req0 = 0;
    req1 = 0;
    check("ack_latency_first", lat[first], 1);
    if (mask == 3) check("ack_latency_second", lat[second], n1 + 3);
    check("txn_completed", int'((gotd[0] || !want[0]) && (gotd[1] || !want[1])), 1);
  endtask

  task automatic set_rect(int r, int x, int y, int w, int h, int c);
    rx[r] = x; ry[r] = y; rw[r] = w; rh[r] = h; rc[r] = c;
  endtask

  initial begin
    int t;
    resetn = 1'b1;
    apply_reset();

    set_rect(0, 10, 20, 1, 1, 4);
    set_rect(1, 0, 0, 0, 0, 0);
    do_txn(1, 0);
    @(negedge clk);
    check("busy_low_after_done", int'(busy), 0);

    apply_reset();
    set_rect(0, 5, 6, 1, 1, 2);
    set_rect(1, 50, 60, 1, 1, 7);
    do_txn(3, 0);
    set_rect(0, 70, 8, 1, 1, 1);
    set_rect(1, 90, 9, 1, 1, 6);
    do_txn(3, 0);

    set_rect(1, 158, 119, 3, 1, 5);
    do_txn(2, 0);

    set_rect(0, 159, 119, 0, 0, 3);
    do_txn(1, 0);

    set_rect(0, 30, 40, 3, 3, 5);
    push_rect(0, 30, 40, 3, 3, 5);
    @(negedge clk);
    drive_inputs();
    req0 = 1;
    t = 0;
    while (t < 5 && !ack0) begin
      @(negedge clk);
      t++;
    end
    req0 = 0;
    check("ack_latency_before_reset", t, 1);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    #1 check("reset_mid_draw", int'({writeEn, busy, done0, ack0}), 0);
    exp_q.delete();
    fav = 0;
    @(negedge clk);
    resetn = 1'b0;
    do_txn(1, 0);

    set_rect(0, 100, 100, 3, 3, 6);
    set_rect(1, 1, 2, 2, 2, 3);
    do_txn(1, 4);
    repeat (5) @(negedge clk);
    check("idle_after_dropped_req1", int'(busy), 0);

    for (int k = 0; k < 30; k++) begin
      for (int r = 0; r < 2; r++) begin
        set_rect(r,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119)),
                 ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 7)));
      end
      do_txn(int'($urandom_range(1, 3)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
